// File: rtl/axi_lite_master_bridge.sv
// rtl/axi_lite_master_bridge.sv - core req/gnt/rvalid data bus to AXI4-Lite master bridge
module axi_lite_master_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic [31:0] m_awaddr,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic        m_bvalid,
  input  logic [1:0]  m_bresp,
  output logic        m_bready,
  output logic [31:0] m_araddr,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rvalid,
  output logic        m_rready
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WADDR = 3'd1,
    S_WRESP = 3'd2,
    S_RADDR = 3'd3,
    S_RRESP = 3'd4
  } state_t;

  // The watchdog fires in the TIMEOUT_CYCLES-th cycle spent outside IDLE.
  localparam bit          LP_WDOG_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] LP_WDOG_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;

  state_t      r_state;
  logic        r_aw_done;
  logic        r_w_done;
  logic [31:0] r_wdog_cnt;

  logic w_aw_hs;
  logic w_w_hs;
  logic w_aw_fin;
  logic w_w_fin;
  logic w_rsp_hs;
  logic w_timeout;

  assign data_gnt_o = (r_state == S_IDLE) && data_req_i;
  assign w_aw_hs    = m_awvalid && m_awready;
  assign w_w_hs     = m_wvalid && m_wready;
  assign w_aw_fin   = r_aw_done || w_aw_hs;
  assign w_w_fin    = r_w_done || w_w_hs;
  // A response accepted in the timeout cycle wins over the forced error.
  assign w_rsp_hs   = ((r_state == S_WRESP) && m_bvalid && m_bready) ||
                      ((r_state == S_RRESP) && m_rvalid && m_rready);
  assign w_timeout  = LP_WDOG_EN && (r_state != S_IDLE) && (r_wdog_cnt == LP_WDOG_LAST);

  // Transaction FSM with registered AXI handshakes, watchdog and completion pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_aw_done     <= 1'b0;
      r_w_done      <= 1'b0;
      r_wdog_cnt    <= 32'd0;
      data_rvalid_o <= 1'b0;
      data_rdata_o  <= 32'd0;
      data_err_o    <= 1'b0;
      m_awaddr      <= 32'd0;
      m_awvalid     <= 1'b0;
      m_wdata       <= 32'd0;
      m_wstrb       <= 4'd0;
      m_wvalid      <= 1'b0;
      m_bready      <= 1'b0;
      m_araddr      <= 32'd0;
      m_arvalid     <= 1'b0;
      m_rready      <= 1'b0;
    end else begin
      data_rvalid_o <= 1'b0;
      if (r_state != S_IDLE) begin
        r_wdog_cnt <= r_wdog_cnt + 32'd1;
      end
      if (w_timeout && !w_rsp_hs) begin
        // Abandon the transaction: drop every valid/ready and report an error.
        m_awvalid     <= 1'b0;
        m_wvalid      <= 1'b0;
        m_arvalid     <= 1'b0;
        m_bready      <= 1'b0;
        m_rready      <= 1'b0;
        data_rvalid_o <= 1'b1;
        data_err_o    <= 1'b1;
        data_rdata_o  <= 32'd0;
        r_state       <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (data_req_i) begin
              r_wdog_cnt <= 32'd0;
              m_awaddr   <= data_addr_i;
              m_araddr   <= data_addr_i;
              m_wdata    <= data_wdata_i;
              m_wstrb    <= data_be_i;
              r_aw_done  <= 1'b0;
              r_w_done   <= 1'b0;
              if (data_we_i) begin
                m_awvalid <= 1'b1;
                m_wvalid  <= 1'b1;
                r_state   <= S_WADDR;
              end else begin
                m_arvalid <= 1'b1;
                r_state   <= S_RADDR;
              end
            end
          end
          S_WADDR: begin
            // AW and W complete independently, in either order.
            if (w_aw_hs) begin
              m_awvalid <= 1'b0;
              r_aw_done <= 1'b1;
            end
            if (w_w_hs) begin
              m_wvalid <= 1'b0;
              r_w_done <= 1'b1;
            end
            if (w_aw_fin && w_w_fin) begin
              m_bready <= 1'b1;
              r_state  <= S_WRESP;
            end
          end
          S_WRESP: begin
            if (m_bvalid) begin
              m_bready      <= 1'b0;
              data_rvalid_o <= 1'b1;
              data_err_o    <= (m_bresp != 2'b00);
              data_rdata_o  <= 32'd0;
              r_state       <= S_IDLE;
            end
          end
          S_RADDR: begin
            if (m_arready) begin
              m_arvalid <= 1'b0;
              m_rready  <= 1'b1;
              r_state   <= S_RRESP;
            end
          end
          S_RRESP: begin
            if (m_rvalid) begin
              m_rready      <= 1'b0;
              data_rvalid_o <= 1'b1;
              data_err_o    <= (m_rresp != 2'b00);
              data_rdata_o  <= m_rdata;
              r_state       <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// tb/tb_axi_lite_master_bridge.sv - self-checking bench for axi_lite_master_bridge
module tb_axi_lite_master_bridge;

  localparam int TO = 8;
  localparam int NEVER = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        data_req_i = 1'b0;
  logic        data_gnt_o;
  logic [31:0] data_addr_i = 32'd0;
  logic        data_we_i = 1'b0;
  logic [3:0]  data_be_i = 4'd0;
  logic [31:0] data_wdata_i = 32'd0;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        data_err_o;
  logic [31:0] m_awaddr;
  logic        m_awvalid;
  logic        m_awready = 1'b0;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wvalid;
  logic        m_wready = 1'b0;
  logic        m_bvalid = 1'b0;
  logic [1:0]  m_bresp = 2'b00;
  logic        m_bready;
  logic [31:0] m_araddr;
  logic        m_arvalid;
  logic        m_arready = 1'b0;
  logic [31:0] m_rdata = 32'd0;
  logic [1:0]  m_rresp = 2'b00;
  logic        m_rvalid = 1'b0;
  logic        m_rready;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] slave_reg = 32'd0;

  always #5 clk = ~clk;

  axi_lite_master_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_addr_i(data_addr_i),
    .data_we_i(data_we_i), .data_be_i(data_be_i), .data_wdata_i(data_wdata_i),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: response handshake lands in cycle 2 + phase stall + response delay;
  // completion follows one cycle later unless the watchdog cuts in first.
  function automatic int ref_hs_cycle(input int phase_d, input int resp_d);
    return 2 + phase_d + resp_d;
  endfunction

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic clear_slave();
    m_awready = 1'b0; m_wready = 1'b0; m_arready = 1'b0;
    m_bvalid = 1'b0; m_bresp = 2'b00; m_rvalid = 1'b0; m_rresp = 2'b00; m_rdata = 32'd0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_gnt_rv_err"}, {data_gnt_o, data_rvalid_o, data_err_o}, 64'd0);
    chk({tag, "_rdata"}, data_rdata_o, 64'd0);
    chk({tag, "_awaddr"}, m_awaddr, 64'd0);
    chk({tag, "_araddr"}, m_araddr, 64'd0);
    chk({tag, "_wdata_wstrb"}, {m_wdata, m_wstrb}, 64'd0);
    chk({tag, "_valid_ready"}, {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}, 64'd0);
  endtask

  // One transaction: slave stalls AW/AR by da cycles, W by dw, responds db cycles after address phase.
  task automatic run_txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input int da, input int dw, input int db,
                         input logic [1:0] resp, input logic [31:0] rd);
    int phase_d, hs, exp_done, done_c;
    bit tmo, exp_err;
    logic [31:0] exp_rd;
    int aw_hs, w_hs, ar_hs, aw_hi, w_hi, ar_hi, aw_c, w_c, ar_c;
    bit rsp_done;
    phase_d  = we ? ((da > dw) ? da : dw) : da;
    hs       = ref_hs_cycle(phase_d, db);
    tmo      = (hs > TO);
    exp_done = tmo ? TO + 1 : hs + 1;
    exp_err  = tmo ? 1'b1 : (resp != 2'b00);
    exp_rd   = (we || tmo) ? 32'd0 : rd;
    aw_hs = 0; w_hs = 0; ar_hs = 0; aw_hi = 0; w_hi = 0; ar_hi = 0;
    aw_c = -1; w_c = -1; ar_c = -1; rsp_done = 1'b0; done_c = -1;
    data_req_i = 1'b1; data_we_i = we; data_addr_i = addr; data_wdata_i = wdata; data_be_i = be;
    #1;
    chk("gnt_in_idle", data_gnt_o, 1);
    @(negedge clk);
    data_req_i = 1'b0; data_addr_i = $urandom; data_wdata_i = $urandom; data_be_i = 4'($urandom);
    for (int c = 1; c <= 40; c++) begin
      if (data_rvalid_o) begin
        done_c = c;
        break;
      end
      m_awready = (c >= 1 + da);
      m_arready = (c >= 1 + da);
      m_wready  = (c >= 1 + dw);
      m_bvalid = 1'b0; m_rvalid = 1'b0; m_bresp = 2'b00; m_rresp = 2'b00; m_rdata = 32'd0;
      if (we && aw_c >= 0 && w_c >= 0 && !rsp_done && c >= ((aw_c > w_c) ? aw_c : w_c) + 1 + db) begin
        m_bvalid = 1'b1; m_bresp = resp;
      end
      if (!we && ar_c >= 0 && !rsp_done && c >= ar_c + 1 + db) begin
        m_rvalid = 1'b1; m_rresp = resp; m_rdata = rd;
      end
      #1;
      if (m_awvalid) begin aw_hi++; chk("awaddr_stable", m_awaddr, addr); end
      if (m_wvalid) begin w_hi++; chk("wdata_wstrb_stable", {m_wdata, m_wstrb}, {wdata, be}); end
      if (m_arvalid) begin ar_hi++; chk("araddr_stable", m_araddr, addr); end
      if (m_awvalid && m_awready) begin aw_hs++; aw_c = c; end
      if (m_wvalid && m_wready) begin
        w_hs++; w_c = c;
        for (int b = 0; b < 4; b++) if (m_wstrb[b]) slave_reg[8*b +: 8] = m_wdata[8*b +: 8];
      end
      if (m_arvalid && m_arready) begin ar_hs++; ar_c = c; end
      if ((m_bvalid && m_bready) || (m_rvalid && m_rready)) rsp_done = 1'b1;
      @(negedge clk);
    end
    clear_slave();
    chk("completion_seen", (done_c > 0), 1);
    chk("completion_cycle", done_c, exp_done);
    chk("err", data_err_o, exp_err);
    chk("rdata", data_rdata_o, exp_rd);
    chk("all_valids_low", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}, 0);
    chk("aw_handshakes", aw_hs, (we && da + 1 <= TO) ? 1 : 0);
    chk("w_handshakes", w_hs, (we && dw + 1 <= TO) ? 1 : 0);
    chk("ar_handshakes", ar_hs, (!we && da + 1 <= TO) ? 1 : 0);
    chk("aw_valid_cycles", aw_hi, we ? min2(da + 1, TO) : 0);
    chk("w_valid_cycles", w_hi, we ? min2(dw + 1, TO) : 0);
    chk("ar_valid_cycles", ar_hi, we ? 0 : min2(da + 1, TO));
    @(negedge clk);
    chk("rvalid_one_cycle", data_rvalid_o, 0);
    chk("rdata_holds", data_rdata_o, exp_rd);
  endtask

  initial begin
    int da, dw, db, n_done, g, r;
    logic [1:0] resp;
    logic [31:0] b2b_addr [3];
    logic [31:0] b2b_dat [3];

    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // GPIO write then read
    run_txn(1'b1, 32'h4, 32'h0000_A5A5, 4'hF, 0, 0, 0, 2'b00, 32'd0);
    chk("gpio_out", slave_reg, 32'h0000_A5A5);
    run_txn(1'b0, 32'h0, 32'd0, 4'h0, 0, 0, 0, 2'b00, 32'h0000_1234);

    // stalled AW, then stalled W
    run_txn(1'b1, 32'h100, 32'hDEAD_BEEF, 4'h5, 5, 0, 0, 2'b00, 32'd0);
    run_txn(1'b1, 32'h104, 32'hCAFE_F00D, 4'hA, 0, 5, 0, 2'b00, 32'd0);

    // error response on read, then watchdog on write and on read
    run_txn(1'b0, 32'h200, 32'd0, 4'h0, 0, 0, 1, 2'b10, 32'h7777_0000);
    run_txn(1'b1, 32'h300, 32'h1111_2222, 4'hF, 0, 0, NEVER, 2'b00, 32'd0);
    run_txn(1'b0, 32'h304, 32'd0, 4'h0, 0, 0, NEVER, 2'b00, 32'h5555_5555);
    run_txn(1'b0, 32'h308, 32'd0, 4'h0, NEVER, 0, 0, 2'b00, 32'h5555_5555);

    // random transactions, occasionally long enough to hit the watchdog
    for (int i = 0; i < 24; i++) begin
      da = $urandom_range(0, 3);
      dw = $urandom_range(0, 3);
      db = ($urandom_range(0, 5) == 0) ? $urandom_range(3, 9) : $urandom_range(0, 2);
      resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      run_txn(1'($urandom), $urandom, $urandom, 4'($urandom), da, dw, db, resp, $urandom);
    end

    // back-to-back reads with an always-ready, immediately-responding slave
    for (int i = 0; i < 3; i++) begin
      b2b_addr[i] = $urandom;
      b2b_dat[i]  = $urandom;
    end
    n_done = 0; g = 0; r = 0;
    data_we_i = 1'b0;
    for (int c = 0; c <= 10; c++) begin
      data_req_i  = (g < 3);
      data_addr_i = (g < 3) ? b2b_addr[g] : 32'd0;
      m_arready = 1'b1;
      m_rvalid  = 1'b1;
      m_rresp   = 2'b00;
      m_rdata   = (r < 3) ? b2b_dat[r] : 32'd0;
      #1;
      chk("b2b_gnt", data_gnt_o, (c % 3 == 0) && (c <= 6));
      chk("b2b_rvalid", data_rvalid_o, (c % 3 == 0) && (c >= 3) && (c <= 9));
      if (data_rvalid_o) begin
        n_done++;
        if (c % 3 == 0 && c >= 3 && c <= 9) chk("b2b_rdata", data_rdata_o, b2b_dat[c / 3 - 1]);
      end
      if (m_arvalid) chk("b2b_araddr", m_araddr, b2b_addr[(g > 0) ? g - 1 : 0]);
      if (data_gnt_o) g++;
      if (m_rvalid && m_rready) r++;
      @(negedge clk);
    end
    chk("b2b_completions", n_done, 3);
    data_req_i = 1'b0;
    clear_slave();
    @(negedge clk);

    // reset while waiting in RRESP
    data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'hABCD_0010;
    @(negedge clk);
    data_req_i = 1'b0;
    m_arready = 1'b1;
    @(negedge clk);
    m_arready = 1'b0;
    #1;
    chk("in_rresp", m_rready, 1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    m_rvalid = 1'b1; m_rdata = 32'h9999_9999;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("no_completion_after_reset", {data_rvalid_o, data_rdata_o}, 0);
    end
    clear_slave();
    @(negedge clk);
    run_txn(1'b0, 32'h40, 32'd0, 4'h0, 1, 0, 1, 2'b00, 32'h0BAD_F00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axi_lite_master_bridge.md
# axi_lite_master_bridge

Converts the core's single-outstanding request/grant/rvalid data bus into AXI4-Lite master transactions. It sits between the cv32e40p data port and the interconnect, driving every AXI-Lite slave in the SoC, including the GPIO and other always-ready peripherals. One transaction is in flight at a time. A watchdog terminates transactions that receive no response and returns an error to the core.

## Interface
Parameters:
- TIMEOUT_CYCLES, 256: cycles allowed per transaction before forced error completion; 0 disables the watchdog.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- data_req_i  in  1  core request.
- data_gnt_o  out  1  request accepted.
- data_addr_i  in  32  byte address.
- data_we_i  in  1  1 = write.
- data_be_i  in  4  byte enables.
- data_wdata_i  in  32  write data.
- data_rvalid_o  out  1  completion pulse, 1 cycle.
- data_rdata_o  out  32  read data, valid with data_rvalid_o.
- data_err_o  out  1  error flag, valid with data_rvalid_o.
- m_awaddr, m_awvalid  out  32, 1  / m_awready  in  1.
- m_wdata, m_wstrb, m_wvalid  out  32, 4, 1  / m_wready  in  1.
- m_bvalid, m_bresp  in  1, 2  / m_bready  out  1.
- m_araddr, m_arvalid  out  32, 1  / m_arready  in  1.
- m_rdata, m_rresp, m_rvalid  in  32, 2, 1  / m_rready  out  1.
- Slaves with no resp output tie m_bresp and m_rresp to 2'b00.

## Operation
- FSM states: IDLE, WADDR, WRESP, RADDR, RRESP.
- IDLE: data_gnt_o = data_req_i (combinational, only in IDLE). On grant, register addr, be, wdata and we, then go to WADDR if we=1, else RADDR.
- WADDR:
  - m_awvalid and m_wvalid are asserted together. Each is tracked independently by flags aw_done and w_done.
  - Each valid drops in the cycle after its own handshake.
  - When both are done, go to WRESP.
- WRESP: m_bready = 1. On m_bvalid, capture err = (m_bresp != 2'b00), then go to IDLE and issue a completion.
- RADDR: m_arvalid is asserted until m_arready, then go to RRESP.
- RRESP: m_rready = 1. On m_rvalid, capture m_rdata, set err = (m_rresp != 2'b00), then go to IDLE and issue a completion.
- Completion: data_rvalid_o is registered high for exactly 1 cycle.
  - data_rdata_o = captured read data on reads and 0 on writes.
  - data_rdata_o holds its value until the next completion.
- Write strobes: m_wstrb = captured data_be_i, unmodified. m_awaddr and m_araddr = captured address, unmodified.
- Watchdog:
  - A counter clears on grant and increments every cycle outside IDLE.
  - On reaching TIMEOUT_CYCLES while no response handshake is occurring in that cycle: drop all AXI valids, go to IDLE, complete with data_err_o=1 and data_rdata_o=0.
  - A response handshake in the same cycle as the timeout takes priority; it completes normally.
- Outputs are not gated by address; decoding is done by the interconnect.

## Timing
- Reset values:
  - All valid/ready outputs: 0.
  - data_rvalid_o=0, data_err_o=0, data_rdata_o=0.
  - m_awaddr, m_araddr, m_wdata, m_wstrb: 0.
  - State: IDLE.
- Latency with an always-ready slave that responds one cycle after the address phase:
  - Cycle 0: grant.
  - Cycle 1: AW/W or AR handshake.
  - Cycle 2: B/R handshake.
  - Cycle 3: data_rvalid_o.
  - Total: 3 cycles from grant to completion.
- The FSM is in IDLE during the completion cycle, so a new grant may coincide with data_rvalid_o. Back-to-back throughput is one transaction per 3 cycles.
- AXI rules:
  - A valid never drops before its handshake.
  - Address and data are stable while valid is high.
  - The master never raises a valid in the cycle after that channel's handshake; this prevents double-acceptance by slaves that sample valid continuously.
- W accepted before AW, or AW before W: both orders must work, and the FSM stays in WADDR until both are done.
- data_gnt_o is 0 in every state except IDLE.
- Reset mid-transaction: everything returns to reset values immediately. No completion is issued.

## Test plan
- Write to the GPIO slave: addr 0x4, wdata 0x0000_A5A5, be 4'hF. Require:
  - m_awvalid and m_wvalid high for 1 cycle.
  - data_rvalid_o at grant+3 with err=0.
  - Slave output reads 0xA5A5.
- Read from the GPIO slave at addr 0x0 with gpio_in = 0x1234. Require data_rvalid_o at grant+3 with data_rdata_o = 0x0000_1234 and err=0.
- Stalled slave:
  - m_awready held low for 5 cycles while m_wready=1. Require m_awvalid and m_awaddr stable throughout, m_wvalid low after its handshake, and completion after m_bvalid.
  - Repeat with m_wready delayed instead of m_awready.
- Error response: m_rresp = 2'b10 on a read. Require data_err_o=1 with data_rvalid_o.
- Timeout: TIMEOUT_CYCLES=8 and a slave that never asserts m_bvalid. Require completion with err=1 and rdata=0 after 8 cycles, the FSM back in IDLE, and the next request granted.
- Back-to-back and reset:
  - Hold data_req_i high across 3 reads. Require a grant in each completion cycle and 3 completions in 9 cycles.
  - Assert rst_n low during RRESP. Require all outputs at their reset values and no data_rvalid_o.
